// File: rtl/output_buffer.sv
// rtl/output_buffer.sv - column-filtering AXI-Stream output stage with one-entry output register
module output_buffer #(
    parameter int DATA_WIDTH         = 8,
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int OUTPUT_HEIGHT      = 480,
    parameter int PROC_LATENCY       = 1
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [DATA_WIDTH-1:0]           result_R,
    input  logic [DATA_WIDTH-1:0]           result_G,
    input  logic [DATA_WIDTH-1:0]           result_B,
    input  logic                            is_full_columns_first_input,
    input  logic                            data_flowing,
    output logic                            output_has_back_pressure,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_tstrb,
    output logic                            m_tlast
);

    localparam int CW = $clog2(OUTPUT_HEIGHT + 1);
    localparam int TW = C_AXIS_TDATA_WIDTH;
    localparam int PW = 4 * DATA_WIDTH;

    logic          marker_in;
    logic          start;
    logic          capture;
    logic [TW-1:0] pixel;

    logic [CW-1:0] row_cnt_q, row_cnt_d;
    logic          tvalid_q, tvalid_d;
    logic          tlast_q, tlast_d;
    logic [TW-1:0] tdata_q, tdata_d;

    assign marker_in = is_full_columns_first_input && data_flowing;

    // The marker travels alongside its pixel through the processing block, so it only advances when data flows.
    generate
        if (PROC_LATENCY == 0) begin : g_no_delay
            assign start = marker_in;
        end else begin : g_delay
            logic [PROC_LATENCY-1:0] marker_q, marker_d;

            always_comb begin
                marker_d = marker_q;
                if (data_flowing) begin
                    marker_d[0] = marker_in;
                    for (int i = 1; i < PROC_LATENCY; i++) begin
                        marker_d[i] = marker_q[i-1];
                    end
                end
            end

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    marker_q <= '0;
                end else begin
                    marker_q <= marker_d;
                end
            end

            assign start = marker_q[PROC_LATENCY-1];
        end
    endgenerate

    // R,G,B sit above a zero byte lane; any bits beyond that stay zero.
    generate
        if (TW >= PW) begin : g_pack_wide
            assign pixel = TW'({result_R, result_G, result_B, {DATA_WIDTH{1'b0}}});
        end else begin : g_pack_narrow
            assign pixel = TW'({result_R, result_G, result_B});
        end
    endgenerate

    assign capture = data_flowing && (start || (row_cnt_q != '0));

    always_comb begin
        row_cnt_d = row_cnt_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        tdata_d   = tdata_q;

        if (data_flowing) begin
            if (start) begin
                row_cnt_d = CW'(OUTPUT_HEIGHT - 1);
            end else if (row_cnt_q != '0) begin
                row_cnt_d = row_cnt_q - CW'(1);
            end
        end

        // A fresh capture wins over a drain in the same cycle.
        if (capture) begin
            tdata_d  = pixel;
            tvalid_d = 1'b1;
            tlast_d  = start ? (OUTPUT_HEIGHT == 1) : (row_cnt_q == CW'(1));
        end else if (tvalid_q && m_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            row_cnt_q <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tdata_q   <= '0;
        end else begin
            row_cnt_q <= row_cnt_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tdata_q   <= tdata_d;
        end
    end

    assign m_tvalid                 = tvalid_q;
    assign m_tlast                  = tlast_q;
    assign m_tdata                  = tdata_q;
    assign m_tstrb                  = '1;
    assign output_has_back_pressure = tvalid_q && !m_tready;

endmodule

// File: tb/tb_output_buffer.sv
// tb/tb_output_buffer.sv - vector table plus scoreboard bench for output_buffer
module tb_output_buffer;

    typedef struct {
        bit          df;
        bit          mk;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        bit          push;
        logic [31:0] data;
        bit          last;
    } vec_t;

    logic        aclk = 1'b0;
    logic        aresetn;

    logic [7:0]  a_r, a_g, a_b;
    logic        a_mk, a_df, a_ready;
    logic        a_bp, a_tvalid, a_tlast;
    logic [31:0] a_tdata;
    logic [3:0]  a_tstrb;

    logic [7:0]  b_r, b_g, b_b;
    logic        b_mk, b_df, b_ready;
    logic        b_bp, b_tvalid, b_tlast;
    logic [31:0] b_tdata;
    logic [3:0]  b_tstrb;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] sb[$];
    vec_t        vecs[24];

    always #5 aclk = ~aclk;

    output_buffer #(.DATA_WIDTH(8), .C_AXIS_TDATA_WIDTH(32), .OUTPUT_HEIGHT(4), .PROC_LATENCY(1)) dut_a (
        .aclk(aclk), .aresetn(aresetn),
        .result_R(a_r), .result_G(a_g), .result_B(a_b),
        .is_full_columns_first_input(a_mk), .data_flowing(a_df),
        .output_has_back_pressure(a_bp), .m_tvalid(a_tvalid), .m_tready(a_ready),
        .m_tdata(a_tdata), .m_tstrb(a_tstrb), .m_tlast(a_tlast)
    );

    output_buffer #(.DATA_WIDTH(8), .C_AXIS_TDATA_WIDTH(32), .OUTPUT_HEIGHT(1), .PROC_LATENCY(0)) dut_b (
        .aclk(aclk), .aresetn(aresetn),
        .result_R(b_r), .result_G(b_g), .result_B(b_b),
        .is_full_columns_first_input(b_mk), .data_flowing(b_df),
        .output_has_back_pressure(b_bp), .m_tvalid(b_tvalid), .m_tready(b_ready),
        .m_tdata(b_tdata), .m_tstrb(b_tstrb), .m_tlast(b_tlast)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input bit df, input bit mk, input logic [7:0] r, input logic [7:0] g,
                               input logic [7:0] b, input bit push, input logic [31:0] data, input bit last);
        vec_t t;
        t.df = df; t.mk = mk; t.r = r; t.g = g; t.b = b;
        t.push = push; t.data = data; t.last = last;
        return t;
    endfunction

    task automatic drive(input vec_t t, input bit rdy);
        a_df = t.df; a_mk = t.mk; a_r = t.r; a_g = t.g; a_b = t.b; a_ready = rdy;
        if (t.push) sb.push_back({t.last, t.data});
        @(posedge aclk);
        #1;
    endtask

    // Scoreboard: every accepted beat must match the oldest expected beat.
    always @(negedge aclk) begin
        if (aresetn && a_tvalid && a_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got tdata 0x%08h tlast %0d, expected no beat", a_tdata, a_tlast);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                chk("beat_tdata", a_tdata, e[31:0]);
                chk("beat_tlast", {31'd0, a_tlast}, {31'd0, e[32]});
            end
        end
    end

    always @(negedge aclk) begin
        if (aresetn && a_df && a_bp) begin
            checks++;
            errors++;
            $display("FAIL upstream_contract: data_flowing 1 while back pressure 1, expected 0");
        end
    end

    initial begin
        vecs[0]  = v(1, 1, 8'h00, 8'h00, 8'h00, 0, 32'h0, 0);
        vecs[1]  = v(1, 0, 8'h10, 8'h00, 8'h00, 1, 32'h10000000, 0);
        vecs[2]  = v(1, 0, 8'h20, 8'h00, 8'h00, 1, 32'h20000000, 0);
        vecs[3]  = v(1, 0, 8'h30, 8'h00, 8'h00, 1, 32'h30000000, 0);
        vecs[4]  = v(1, 0, 8'h40, 8'h00, 8'h00, 1, 32'h40000000, 1);
        vecs[5]  = v(1, 0, 8'h50, 8'h00, 8'h00, 0, 32'h0, 0);
        vecs[6]  = v(1, 1, 8'h99, 8'h99, 8'h99, 0, 32'h0, 0);
        vecs[7]  = v(0, 0, 8'hEE, 8'h00, 8'h00, 0, 32'h0, 0);
        vecs[8]  = v(1, 0, 8'h11, 8'h22, 8'h33, 1, 32'h11223300, 0);
        vecs[9]  = v(0, 0, 8'hEE, 8'h00, 8'h00, 0, 32'h0, 0);
        vecs[10] = v(0, 0, 8'hEE, 8'h00, 8'h00, 0, 32'h0, 0);
        vecs[11] = v(1, 0, 8'h22, 8'h00, 8'h00, 1, 32'h22000000, 0);
        vecs[12] = v(1, 0, 8'h33, 8'h00, 8'h00, 1, 32'h33000000, 0);
        vecs[13] = v(0, 0, 8'hEE, 8'h00, 8'h00, 0, 32'h0, 0);
        vecs[14] = v(1, 0, 8'h44, 8'h55, 8'h66, 1, 32'h44556600, 1);
        vecs[15] = v(1, 0, 8'h55, 8'h00, 8'h00, 0, 32'h0, 0);
        vecs[16] = v(1, 1, 8'h00, 8'h00, 8'h00, 0, 32'h0, 0);
        vecs[17] = v(1, 0, 8'h61, 8'h00, 8'h00, 1, 32'h61000000, 0);
        vecs[18] = v(1, 1, 8'h62, 8'h00, 8'h00, 1, 32'h62000000, 0);
        vecs[19] = v(1, 0, 8'h63, 8'h01, 8'h02, 1, 32'h63010200, 0);
        vecs[20] = v(1, 0, 8'h64, 8'h00, 8'h00, 1, 32'h64000000, 0);
        vecs[21] = v(1, 0, 8'h65, 8'h00, 8'h00, 1, 32'h65000000, 0);
        vecs[22] = v(1, 0, 8'h66, 8'h00, 8'h00, 1, 32'h66000000, 1);
        vecs[23] = v(1, 0, 8'h67, 8'h00, 8'h00, 0, 32'h0, 0);

        aresetn = 1'b0;
        a_df = 0; a_mk = 0; a_r = 0; a_g = 0; a_b = 0; a_ready = 1;
        b_df = 0; b_mk = 0; b_r = 0; b_g = 0; b_b = 0; b_ready = 1;
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_tvalid", {31'd0, a_tvalid}, 32'd0);
        chk("rst_tdata", a_tdata, 32'd0);
        chk("rst_tlast", {31'd0, a_tlast}, 32'd0);
        chk("rst_bp", {31'd0, a_bp}, 32'd0);
        chk("tstrb", {28'd0, a_tstrb}, 32'hF);
        #2 aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Zero latency, single-row column: marker and pixel share a cycle.
        b_df = 1; b_mk = 1; b_r = 8'hAA;
        @(posedge aclk);
        #1;
        chk("h1_tvalid", {31'd0, b_tvalid}, 32'd1);
        chk("h1_tdata", b_tdata, 32'hAA000000);
        chk("h1_tlast", {31'd0, b_tlast}, 32'd1);
        b_df = 0; b_mk = 0; b_r = 0;
        @(posedge aclk);
        #1;
        chk("h1_drain_tvalid", {31'd0, b_tvalid}, 32'd0);
        chk("h1_drain_tlast_hold", {31'd0, b_tlast}, 32'd1);

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i], 1'b1);
            chk($sformatf("vec%0d_tvalid", i), {31'd0, a_tvalid}, {31'd0, vecs[i].push});
        end

        // Sink stall after the first beat of a column.
        drive(v(1, 1, 8'h00, 8'h00, 8'h00, 0, 32'h0, 0), 1'b1);
        drive(v(1, 0, 8'h10, 8'h00, 8'h00, 1, 32'h10000000, 0), 1'b1);
        a_df = 0; a_mk = 0; a_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("stall_bp", {31'd0, a_bp}, 32'd1);
            chk("stall_tvalid", {31'd0, a_tvalid}, 32'd1);
            chk("stall_tdata", a_tdata, 32'h10000000);
            @(posedge aclk);
            #1;
        end
        drive(v(1, 0, 8'h20, 8'h00, 8'h00, 1, 32'h20000000, 0), 1'b1);
        chk("unstall_bp", {31'd0, a_bp}, 32'd0);
        drive(v(1, 0, 8'h30, 8'h00, 8'h00, 1, 32'h30000000, 0), 1'b1);
        drive(v(1, 0, 8'h40, 8'h00, 8'h00, 1, 32'h40000000, 1), 1'b1);
        drive(v(1, 0, 8'h50, 8'h00, 8'h00, 0, 32'h0, 0), 1'b1);
        drive(v(0, 0, 8'h00, 8'h00, 8'h00, 0, 32'h0, 0), 1'b1);

        // Reset mid-column with a stalled beat and a marker in flight.
        drive(v(1, 1, 8'h00, 8'h00, 8'h00, 0, 32'h0, 0), 1'b1);
        drive(v(1, 0, 8'h70, 8'h00, 8'h00, 1, 32'h70000000, 0), 1'b1);
        drive(v(1, 1, 8'h71, 8'h00, 8'h00, 1, 32'h71000000, 0), 1'b1);
        a_df = 0; a_mk = 0; a_ready = 0;
        #2;
        aresetn = 1'b0;
        sb.delete();
        #1;
        chk("arst_tvalid", {31'd0, a_tvalid}, 32'd0);
        chk("arst_tdata", a_tdata, 32'd0);
        chk("arst_tlast", {31'd0, a_tlast}, 32'd0);
        chk("arst_bp", {31'd0, a_bp}, 32'd0);
        chk("arst_b_tdata", b_tdata, 32'd0);
        chk("arst_b_tlast", {31'd0, b_tlast}, 32'd0);
        @(posedge aclk);
        #3 aresetn = 1'b1;
        @(posedge aclk);
        #1;
        for (int i = 0; i < 4; i++) begin
            drive(v(1, 0, 8'h7F, 8'h00, 8'h00, 0, 32'h0, 0), 1'b1);
            chk("post_rst_no_beat", {31'd0, a_tvalid}, 32'd0);
        end

        drive(v(0, 0, 8'h00, 8'h00, 8'h00, 0, 32'h0, 0), 1'b1);
        drive(v(0, 0, 8'h00, 8'h00, 8'h00, 0, 32'h0, 0), 1'b1);
        chk("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
